// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronised line, runtime baud divisor, parity, 1/2 stop bits, break.
// Define UART_RX_MAJORITY_EN to take each bit as the 2-of-3 vote of samples at count-1/0/+1.
module uart_rx (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_rx,
  input  logic        i_rx_en,
  input  logic [15:0] i_baudrate,
  input  logic [1:0]  i_parity_mode,
  input  logic        i_frame_mode,
  output logic [7:0]  o_data,
  output logic        o_data_valid,
  input  logic        i_ready,
  output logic        o_rx_state,
  output logic        o_rx_break,
  output logic        o_parity_err,
  output logic        o_frame_err,
  output logic        o_overrun
);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StBrk} state_e;

  state_e      state_q, state_d;
  logic        rx_meta_q, rx_sync_q, rx_prev_q;
  logic [15:0] cnt_q, cnt_d, n_q, n_d;
  logic [15:0] target, sample_at, cnt_reload;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d, data_q, data_d;
  logic [1:0]  par_mode_q, par_mode_d;
  logic        two_stop_q, two_stop_d, par_bit_q, par_bit_d;
  logic        stop_idx_q, stop_idx_d, stop_err_q, stop_err_d;
  logic        valid_q, valid_d, rx_state_q;
  logic        brk_q, brk_d, perr_q, perr_d, ferr_q, ferr_d, ovr_q, ovr_d;
  logic        tick, bit_val, has_par, complete, frame_bad;

  // Start bit is judged at mid-bit; every later bit one full period after the previous.
  assign target  = (state_q == StStart) ? ({1'b0, n_q[15:1]} - 16'd1) : (n_q - 16'd1);
  assign has_par = par_mode_q[0] ^ par_mode_q[1];

`ifdef UART_RX_MAJORITY_EN
  logic s_early_q, s_mid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s_early_q <= 1'b1;
      s_mid_q   <= 1'b1;
    end else begin
      if (cnt_q == target - 16'd1) s_early_q <= rx_sync_q;
      if (cnt_q == target)         s_mid_q   <= rx_sync_q;
    end
  end

  // Decision lands one clock after nominal, so the counter restarts at 1 to keep the pitch.
  assign sample_at  = target + 16'd1;
  assign cnt_reload = 16'd1;
  assign bit_val    = (s_early_q & s_mid_q) | (s_early_q & rx_sync_q) | (s_mid_q & rx_sync_q);
`else
  assign sample_at  = target;
  assign cnt_reload = 16'd0;
  assign bit_val    = rx_sync_q;
`endif

  assign tick = (cnt_q == sample_at);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 16'd1;
    n_d        = n_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    par_mode_d = par_mode_q;
    two_stop_d = two_stop_q;
    par_bit_d  = par_bit_q;
    stop_idx_d = stop_idx_q;
    stop_err_d = stop_err_q;
    data_d     = data_q;
    valid_d    = valid_q & ~i_ready;
    brk_d      = 1'b0;
    perr_d     = 1'b0;
    ferr_d     = 1'b0;
    ovr_d      = 1'b0;
    complete   = 1'b0;
    frame_bad  = 1'b0;

    if (!i_rx_en) begin
      state_d = StIdle;
      cnt_d   = 16'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          cnt_d = 16'd0;
          if (rx_prev_q && !rx_sync_q) begin
            state_d    = StStart;
            bit_idx_d  = 3'd0;
            n_d        = (i_baudrate < 16'd4) ? 16'd4 : i_baudrate;
            par_mode_d = i_parity_mode;
            two_stop_d = i_frame_mode;
            par_bit_d  = 1'b0;
            stop_idx_d = 1'b0;
            stop_err_d = 1'b0;
          end
        end
        StStart: begin
          if (tick) begin
            cnt_d   = cnt_reload;
            state_d = bit_val ? StIdle : StData;
          end
        end
        StData: begin
          if (tick) begin
            cnt_d     = cnt_reload;
            shift_d   = {bit_val, shift_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) state_d = has_par ? StParity : StStop;
          end
        end
        StParity: begin
          if (tick) begin
            cnt_d     = cnt_reload;
            par_bit_d = bit_val;
            state_d   = StStop;
          end
        end
        StStop: begin
          if (tick) begin
            cnt_d = cnt_reload;
            if (!stop_idx_q) begin
              if (!bit_val && shift_q == 8'h00 && !par_bit_q) begin
                brk_d   = 1'b1;
                state_d = StBrk;
              end else if (two_stop_q) begin
                stop_idx_d = 1'b1;
                stop_err_d = ~bit_val;
              end else begin
                complete  = 1'b1;
                frame_bad = ~bit_val;
              end
            end else begin
              complete  = 1'b1;
              frame_bad = stop_err_q | ~bit_val;
            end
          end
        end
        StBrk: begin
          cnt_d = 16'd0;
          if (rx_sync_q) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end

    if (complete) begin
      state_d = StIdle;
      ferr_d  = frame_bad;
      perr_d  = has_par & ((^{shift_q, par_bit_q}) != (par_mode_q == 2'b01));
      if (valid_q && !i_ready) begin
        ovr_d = 1'b1;
      end else begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      state_q    <= StIdle;
      cnt_q      <= 16'd0;
      n_q        <= 16'd4;
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'h00;
      par_mode_q <= 2'b00;
      two_stop_q <= 1'b0;
      par_bit_q  <= 1'b0;
      stop_idx_q <= 1'b0;
      stop_err_q <= 1'b0;
      data_q     <= 8'h00;
      valid_q    <= 1'b0;
      rx_state_q <= 1'b0;
      brk_q      <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      rx_meta_q  <= i_rx;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      n_q        <= n_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      par_mode_q <= par_mode_d;
      two_stop_q <= two_stop_d;
      par_bit_q  <= par_bit_d;
      stop_idx_q <= stop_idx_d;
      stop_err_q <= stop_err_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      rx_state_q <= i_rx_en;
      brk_q      <= brk_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
    end
  end

  assign o_data       = data_q;
  assign o_data_valid = valid_q;
  assign o_rx_state   = rx_state_q;
  assign o_rx_break   = brk_q;
  assign o_parity_err = perr_q;
  assign o_frame_err  = ferr_q;
  assign o_overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: vector table through a scoreboard plus corner-case sequences.
module tb_uart_rx;

  logic        clk, rst, i_rx, i_rx_en, i_frame_mode, i_ready;
  logic [15:0] i_baudrate;
  logic [1:0]  i_parity_mode;
  logic [7:0]  o_data;
  logic        o_data_valid, o_rx_state, o_rx_break, o_parity_err, o_frame_err, o_overrun;

  uart_rx dut (
    .clk          (clk),
    .rst          (rst),
    .i_rx         (i_rx),
    .i_rx_en      (i_rx_en),
    .i_baudrate   (i_baudrate),
    .i_parity_mode(i_parity_mode),
    .i_frame_mode (i_frame_mode),
    .o_data       (o_data),
    .o_data_valid (o_data_valid),
    .i_ready      (i_ready),
    .o_rx_state   (o_rx_state),
    .o_rx_break   (o_rx_break),
    .o_parity_err (o_parity_err),
    .o_frame_err  (o_frame_err),
    .o_overrun    (o_overrun)
  );

  typedef struct {
    logic [7:0] b;
    logic [1:0] pm;
    logic       pbit;
    logic       fm;
    logic       s1;
    logic       s2;
    int         baud;
    logic       perr;
    logic       ferr;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic       perr;
    logic       ferr;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[13];
  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   brk_cnt = 0, ovr_cnt = 0, perr_cnt = 0, ferr_cnt = 0, valid_hi = 0;
  int   last_rise = 0;
  int   start_cyc = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: count flag pulses and pop the scoreboard on every handshake.
  initial begin
    exp_t e;
    logic valid_prev;
    valid_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        brk_cnt  += int'(o_rx_break);
        ovr_cnt  += int'(o_overrun);
        perr_cnt += int'(o_parity_err);
        ferr_cnt += int'(o_frame_err);
        if (o_data_valid) valid_hi++;
        if (o_data_valid && !valid_prev) last_rise = cyc;
        valid_prev = o_data_valid;
        if (o_data_valid && i_ready) begin
          if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_data: got 0x%0h, expected no byte", o_data);
          end else begin
            e = sb.pop_front();
            check("sb_data", int'(o_data), int'(e.d));
            check("sb_parity_err", int'(o_parity_err), int'(e.perr));
            check("sb_frame_err", int'(o_frame_err), int'(e.ferr));
          end
        end
      end else begin
        valid_prev = 1'b0;
      end
    end
  end

  task automatic drive(input logic v, input int n);
    i_rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input vec_t v);
    int bl;
    bl = (v.baud < 4) ? 4 : v.baud;
    i_baudrate    = 16'(v.baud);
    i_parity_mode = v.pm;
    i_frame_mode  = v.fm;
    start_cyc     = cyc;
    drive(1'b0, bl);
    for (int i = 0; i < 8; i++) drive(v.b[i], bl);
    if (v.pm == 2'b01 || v.pm == 2'b10) drive(v.pbit, bl);
    drive(v.s1, bl);
    if (v.fm) drive(v.s2, bl);
    drive(1'b1, bl);
  endtask

  task automatic send_expect(input vec_t v);
    sb.push_back('{v.b, v.perr, v.ferr});
    send_frame(v);
    repeat (20) @(posedge clk);
    #1;
    check("sb_drained", sb.size(), 0);
  endtask

  initial begin
    vec_t v;
    int   b0, o0, p0, f0, vh0;

    vecs[0]  = '{8'hA5, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 16, 1'b0, 1'b0};
    vecs[1]  = '{8'h03, 2'd2, 1'b1, 1'b0, 1'b1, 1'b1, 16, 1'b1, 1'b0};
    vecs[2]  = '{8'h03, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1, 16, 1'b0, 1'b0};
    vecs[3]  = '{8'h80, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, 16, 1'b0, 1'b0};
    vecs[4]  = '{8'h80, 2'd1, 1'b1, 1'b0, 1'b1, 1'b1, 16, 1'b1, 1'b0};
    vecs[5]  = '{8'h5A, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 16, 1'b0, 1'b1};
    vecs[6]  = '{8'hFF, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 16, 1'b0, 1'b1};
    vecs[7]  = '{8'h00, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 16, 1'b0, 1'b0};
    vecs[8]  = '{8'h3C, 2'd2, 1'b0, 1'b1, 1'b1, 1'b1, 16, 1'b0, 1'b0};
    vecs[9]  = '{8'h96, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 2,  1'b0, 1'b0};
    vecs[10] = '{8'hC3, 2'd1, 1'b1, 1'b0, 1'b1, 1'b1, 7,  1'b0, 1'b0};
    vecs[11] = '{8'h01, 2'd2, 1'b0, 1'b1, 1'b0, 1'b1, 16, 1'b1, 1'b1};
    vecs[12] = '{8'h00, 2'd2, 1'b1, 1'b0, 1'b0, 1'b1, 16, 1'b1, 1'b1};

    rst = 1'b1; i_rx = 1'b1; i_rx_en = 1'b1; i_ready = 1'b1;
    i_baudrate = 16'd16; i_parity_mode = 2'd0; i_frame_mode = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("reset_data", int'(o_data), 0);
    check("reset_flags", int'({o_data_valid, o_rx_state, o_rx_break, o_parity_err,
                               o_frame_err, o_overrun}), 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rx_state_en", int'(o_rx_state), 1);

    // 0xA5 8N1: latency bound and single-cycle valid.
    vh0 = valid_hi; p0 = perr_cnt; f0 = ferr_cnt;
    send_expect(vecs[0]);
    n_tests++;
    if (last_rise - start_cyc > 164 || last_rise < start_cyc) begin
      n_fail++;
      $display("FAIL latency: got %0d clocks, expected <= 164", last_rise - start_cyc);
    end
    check("valid_one_cycle", valid_hi - vh0, 1);
    check("a5_no_flags", (perr_cnt - p0) + (ferr_cnt - f0), 0);

    for (int i = 0; i < 13; i++) send_expect(vecs[i]);

    // Overrun: hold ready low across two bytes.
    i_ready = 1'b0;
    o0 = ovr_cnt;
    v = '{8'h11, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 16, 1'b0, 1'b0};
    send_frame(v);
    v.b = 8'h22;
    send_frame(v);
    repeat (20) @(posedge clk);
    #1;
    check("ovr_data_held", int'(o_data), 8'h11);
    check("ovr_valid_held", int'(o_data_valid), 1);
    check("ovr_pulse_once", ovr_cnt - o0, 1);
    sb.push_back('{8'h11, 1'b0, 1'b0});
    i_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("ovr_drained", sb.size(), 0);
    check("ovr_valid_clr", int'(o_data_valid), 0);

    // Break: 12 bit times low, then a clean frame.
    b0 = brk_cnt; f0 = ferr_cnt; vh0 = valid_hi;
    i_parity_mode = 2'd0; i_frame_mode = 1'b0; i_baudrate = 16'd16;
    drive(1'b0, 12 * 16);
    drive(1'b1, 32);
    check("break_pulse", brk_cnt - b0, 1);
    check("break_no_ferr", ferr_cnt - f0, 0);
    check("break_no_valid", valid_hi - vh0, 0);
    send_expect('{8'h5A, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 16, 1'b0, 1'b0});

    // 6-clock glitch must be rejected as a false start.
    vh0 = valid_hi; p0 = perr_cnt; f0 = ferr_cnt; b0 = brk_cnt;
    drive(1'b0, 6);
    drive(1'b1, 200);
    check("glitch_no_valid", valid_hi - vh0, 0);
    check("glitch_no_flags", (perr_cnt - p0) + (ferr_cnt - f0) + (brk_cnt - b0), 0);

    // Enable dropped mid-frame: frame aborted silently.
    drive(1'b0, 16);
    for (int i = 0; i < 4; i++) drive(1'b0, 16);
    i_rx_en = 1'b0;
    for (int i = 0; i < 4; i++) drive(1'b0, 16);
    drive(1'b1, 40);
    check("dis_rx_state", int'(o_rx_state), 0);
    i_rx_en = 1'b1;
    drive(1'b1, 4);
    check("dis_no_valid", valid_hi - vh0, 0);
    check("dis_no_flags", (perr_cnt - p0) + (ferr_cnt - f0) + (brk_cnt - b0), 0);

    // Reset mid-frame clears pending data and leaves no flags.
    i_ready = 1'b0;
    send_frame('{8'h42, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 16, 1'b0, 1'b0});
    check("pend_data", int'(o_data), 8'h42);
    o0 = ovr_cnt;
    vh0 = valid_hi;
    drive(1'b0, 16);
    for (int i = 0; i < 3; i++) drive(1'b1, 16);
    i_rx = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b1, 200);
    check("rst_mid_data", int'(o_data), 0);
    check("rst_mid_valid", int'(o_data_valid), 0);
    check("rst_mid_flags", (perr_cnt - p0) + (ferr_cnt - f0) + (brk_cnt - b0) + (ovr_cnt - o0), 0);
    i_ready = 1'b1;

    check("sb_final_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
